// File: rtl/adxl_fifo_pkg.sv
// Shared definitions for the ADXL355 sample FIFO: mode encodings, default
// geometry (also used by the register block) and the channel-index width helper.
package adxl_fifo_pkg;

   localparam logic FIFO_MODE_STREAM = 1'b0;   // overwrite oldest frame when full
   localparam logic FIFO_MODE_STOP   = 1'b1;   // drop newest frame when full

   localparam int DEF_DATA_WIDTH = 20;
   localparam int DEF_NUM_CH     = 3;
   localparam int DEF_ADDR_WIDTH = 5;

   // Width of a channel index; a single-channel FIFO still gets one bit.
   function automatic int ch_width(input int num_ch);
      return (num_ch <= 1) ? 1 : $clog2(num_ch);
   endfunction

endpackage

// File: rtl/adxl_sample_fifo_if.sv
// Frame-write / word-read handshake between the filter, the FIFO and the
// register read path. master = client side, slave = FIFO side.
interface adxl_sample_fifo_if
   import adxl_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_CH     = DEF_NUM_CH
);
   localparam int CH_W = ch_width(NUM_CH);

   logic                         wr_en;
   logic [NUM_CH*DATA_WIDTH-1:0] wr_data;
   logic                         rd_req;
   logic [DATA_WIDTH-1:0]        rd_data;
   logic                         rd_valid;
   logic [CH_W-1:0]              rd_ch;

   modport master (output wr_en, wr_data, rd_req,
                   input  rd_data, rd_valid, rd_ch);
   modport slave  (input  wr_en, wr_data, rd_req,
                   output rd_data, rd_valid, rd_ch);
endinterface

// File: rtl/adxl_fifo_ram.sv
// Frame storage: simple dual-port, synchronous write, combinational read.
// Contents are not reset; the pointers decide what is valid.
module adxl_fifo_ram #(
   parameter int WIDTH      = 60,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [WIDTH-1:0]      rdata
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [WIDTH-1:0] mem [DEPTH];

   // Store one frame per write strobe.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/adxl_sample_fifo.sv
// Multi-channel sample FIFO: one NUM_CH-axis frame written per cycle, read back
// one channel word per rising edge of rd_req. Stream/stop-on-full modes,
// flush, sticky overrun/underflow, occupancy count.
// Optional watermark interrupt enabled by defining ADXL_FIFO_WATERMARK_EN.
module adxl_sample_fifo
   import adxl_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   adxl_sample_fifo_if.slave     bus,
   input  logic                  flush,
   input  logic                  clr_flags,
   input  logic                  mode,
   input  logic [ADDR_WIDTH:0]   watermark,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   sample_num,
   output logic                  overrun,
   output logic                  underflow,
   output logic                  wm_irq
);
   localparam int FW = NUM_CH * DATA_WIDTH;
   localparam int CW = ch_width(NUM_CH);
   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         ch_idx;
   logic                  rd_req_p0;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  rd_pulse;
   logic [CW-1:0]         rd_chan;

   logic [FW-1:0]         head;
   logic [DATA_WIDTH-1:0] ch_word;
   logic                  rd_edge, rd_ok, pop;
   logic                  wr_inc, rd_inc, force_ch0, ovr_set, udf_set;
   logic [PW-1:0]         count_n;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                  (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

   assign bus.rd_data  = rd_word;
   assign bus.rd_valid = rd_pulse;
   assign bus.rd_ch    = rd_chan;

   adxl_fifo_ram #(
      .WIDTH      (FW),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_inc),
      .waddr (wr_ptr[ADDR_WIDTH-1:0]),
      .wdata (bus.wr_data),
      .raddr (rd_ptr[ADDR_WIDTH-1:0]),
      .rdata (head)
   );

   // Select the current channel word out of the head frame.
   always_comb begin
      ch_word = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_idx == CW'(i)) ch_word = head[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Per-cycle event decode: read edge, pop, write/overwrite/drop, flags, next count.
   always_comb begin
      rd_edge   = bus.rd_req & ~rd_req_p0;
      rd_ok     = rd_edge && !empty;
      pop       = rd_ok && (ch_idx == LAST_CH);
      wr_inc    = 1'b0;
      rd_inc    = pop;
      force_ch0 = 1'b0;
      ovr_set   = 1'b0;
      udf_set   = rd_edge && empty;
      if (bus.wr_en) begin
         if (!full || pop) begin
            wr_inc = 1'b1;
         end else if (mode == FIFO_MODE_STREAM) begin
            // Overwrite: oldest frame leaves, any partial read of it restarts.
            wr_inc    = 1'b1;
            rd_inc    = 1'b1;
            force_ch0 = 1'b1;
            ovr_set   = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end
      if (flush) begin
         rd_ok     = 1'b0;
         wr_inc    = 1'b0;
         rd_inc    = 1'b0;
         force_ch0 = 1'b0;
         ovr_set   = 1'b0;
         udf_set   = 1'b0;
      end
      count_n = flush ? '0 : (sample_num + PW'(wr_inc) - PW'(rd_inc));
   end

   // Read edge register and the registered read result (word, channel, valid pulse).
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_req_p0 <= 1'b0;
         rd_pulse  <= 1'b0;
         rd_word   <= '0;
         rd_chan   <= '0;
      end else begin
         rd_req_p0 <= bus.rd_req;
         rd_pulse  <= rd_edge && !flush;
         if (rd_edge && !flush) begin
            rd_word <= empty ? '0 : ch_word;
            rd_chan <= ch_idx;
         end
      end
   end

   // Pointers, occupancy count and channel index.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         sample_num <= '0;
         ch_idx     <= '0;
      end else begin
         wr_ptr     <= wr_ptr + PW'(wr_inc);
         rd_ptr     <= rd_ptr + PW'(rd_inc);
         sample_num <= count_n;
         if (force_ch0 || pop) ch_idx <= '0;
         else if (rd_ok)       ch_idx <= ch_idx + 1'b1;
      end
   end

   // Sticky flags: a same-cycle setting event wins over clr_flags; flush keeps them.
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun   <= 1'b0;
         underflow <= 1'b0;
      end else if (!flush) begin
         overrun   <= (overrun   & ~clr_flags) | ovr_set;
         underflow <= (underflow & ~clr_flags) | udf_set;
      end
   end

`ifdef ADXL_FIFO_WATERMARK_EN
   // Watermark level tracks the count being registered this cycle.
   always_ff @(posedge clk) begin
      if (rst) wm_irq <= 1'b0;
      else     wm_irq <= (count_n >= watermark) && (watermark != '0);
   end
`else
   logic unused_watermark;
   assign unused_watermark = ^watermark;
   assign wm_irq = 1'b0;
`endif

endmodule
